// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32x32 multiply / divide unit with architectural HI/LO.
// A radix-2 shift-add multiply or a restoring divide runs for 32 cycles on
// operand magnitudes. The sign fix-up is applied when the result is written,
// so HI/LO change only at the completion edge or on an mthi/mtlo write.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one iteration per edge, 32 in total
// DONE  | result valid in HI/LO, done pulse high
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] bmag;
  logic [31:0] acc;
  logic [31:0] qr;

  logic        is_div;
  logic        is_signed;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [31:0] acc_nxt;
  logic [31:0] qr_nxt;
  logic [63:0] prod;
  logic [63:0] prod_s;
  logic        neg_res;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];
  // Signed ops start from magnitudes; 0x80000000 keeps its magnitude as unsigned.
  assign mag_a_in  = (~op[0] & srca[31]) ? (32'd0 - srca) : srca;
  assign mag_b_in  = (~op[0] & srcb[31]) ? (32'd0 - srcb) : srcb;
  assign neg_res   = is_signed & (a_r[31] ^ b_r[31]);

  // One datapath step: shift-add for multiply, trial subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, bmag} : 33'd0);
    div_trial = {acc, qr[31]};
    div_ge    = (div_trial >= {1'b0, bmag});
    div_diff  = div_trial - {1'b0, bmag};
    if (is_div) begin
      acc_nxt = div_ge ? div_diff[31:0] : div_trial[31:0];
      qr_nxt  = {qr[30:0], div_ge};
    end else begin
      acc_nxt = mul_sum[32:1];
      qr_nxt  = {mul_sum[0], qr[31:1]};
    end
  end

  // Sign fix-up and divide-by-zero override applied to the final step.
  always_comb begin
    prod   = {acc_nxt, qr_nxt};
    prod_s = neg_res ? (64'd0 - prod) : prod;
    hi_res = prod_s[63:32];
    lo_res = prod_s[31:0];
    if (is_div) begin
      if (b_r == 32'd0) begin
        hi_res = a_r;
        lo_res = 32'hFFFF_FFFF;
      end else begin
        lo_res = neg_res ? (32'd0 - qr_nxt) : qr_nxt;
        hi_res = (is_signed & a_r[31]) ? (32'd0 - acc_nxt) : acc_nxt;
      end
    end
  end

  // Control FSM, iteration registers and HI/LO; the result write is last so it beats mthi/mtlo.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      op_r  <= 2'd0;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      bmag  <= 32'd0;
      acc   <= 32'd0;
      qr    <= 32'd0;
    end else begin
      if (mthi) hi <= wd;
      if (mtlo) lo <= wd;
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= 5'd0;
            op_r  <= op;
            a_r   <= srca;
            b_r   <= srcb;
            bmag  <= mag_b_in;
            acc   <= 32'd0;
            qr    <= mag_a_in;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          qr  <= qr_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= hi_res;
            lo    <= lo_res;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit with hand-computed results.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          tests;
  int          fails;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch from IDLE or DONE, run to completion and leave the unit in DONE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit collide);
    int cyc;
    start = 1'b1; op = o; srca = a; srcb = b;
    tick();
    start = 1'b0;
    chk({tag, " launch busy/done"}, {62'd0, busy, done}, 64'd2);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == 16) begin
        chk({tag, " hold hi"}, {32'd0, hi}, {32'd0, m_hi});
        chk({tag, " hold lo"}, {32'd0, lo}, {32'd0, m_lo});
      end
      if (collide && cyc == 32) begin
        mthi = 1'b1; mtlo = 1'b1; wd = 32'hDEAD_BEEF;
      end
      tick();
      mthi = 1'b0; mtlo = 1'b0;
    end
    chk({tag, " busy cycles"}, 64'(cyc), 64'd32);
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int  cyc;
    bit  saw_done;
    tests = 0; fails = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    // Reset asserted together with start/mthi/mtlo: reset must win.
    reset = 1'b1; start = 1'b1; op = 2'b00; srca = 32'd5; srcb = 32'd7;
    mthi = 1'b1; mtlo = 1'b1; wd = 32'hCAFE_F00D;
    tick(); tick();
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    tick();
    chk("idle after reset busy", {63'd0, busy}, 64'd0);

    // mthi and mtlo together, then mthi alone.
    mthi = 1'b1; mtlo = 1'b1; wd = 32'h1122_3344;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt both hi", {32'd0, hi}, 64'h1122_3344);
    chk("mt both lo", {32'd0, lo}, 64'h1122_3344);
    mthi = 1'b1; wd = 32'h0000_0055;
    tick();
    mthi = 1'b0;
    chk("mthi only hi", {32'd0, hi}, 64'h55);
    chk("mthi only lo", {32'd0, lo}, 64'h1122_3344);
    m_hi = 32'h55; m_lo = 32'h1122_3344;

    run_op("MULT 3*-6", 2'b00, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFEE, 1'b0);
    tick();
    chk("done drop", {62'd0, busy, done}, 64'd0);

    // mthi/mtlo on the completion edge: the product must win.
    run_op("MULTU collide", 2'b01, 32'd3, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFEE, 1'b1);
    // Back-to-back from DONE; run_op checks that done has dropped at launch.
    run_op("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    tick();
    run_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    tick();
    run_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'h0000_000E, 1'b0);
    tick();
    run_op("DIVU by zero", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    tick();
    run_op("DIV by zero", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);
    tick();
    run_op("DIV min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    tick();
    run_op("MULT min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
    tick();

    // Start while busy is ignored; mtlo mid-run is visible until completion.
    start = 1'b1; op = 2'b00; srca = 32'h0001_0000; srcb = 32'h0000_0300;
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == 11) chk("mtlo mid-run lo", {32'd0, lo}, 64'hA5A5_A5A5);
      if (cyc == 5) begin
        start = 1'b1; op = 2'b11; srca = 32'hFFFF_FFFF; srcb = 32'd2;
      end
      if (cyc == 10) begin
        mtlo = 1'b1; wd = 32'hA5A5_A5A5;
      end
      tick();
      start = 1'b0; mtlo = 1'b0;
    end
    chk("ignored start cycles", 64'(cyc), 64'd32);
    chk("ignored start done", {63'd0, done}, 64'd1);
    chk("ignored start hi", {32'd0, hi}, 64'd0);
    chk("ignored start lo", {32'd0, lo}, 64'h0300_0000);
    m_hi = 32'd0; m_lo = 32'h0300_0000;
    tick();

    // Reset in the middle of a DIV discards it.
    start = 1'b1; op = 2'b10; srca = 32'hFFFF_FFF9; srcb = 32'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("pre-reset busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid reset busy/done", {62'd0, busy, done}, 64'd0);
    chk("mid reset hi", {32'd0, hi}, 64'd0);
    chk("mid reset lo", {32'd0, lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    chk("no pulse after reset", {63'd0, saw_done}, 64'd0);
    run_op("DIVU after reset", 2'b11, 32'd100, 32'd7, 32'd2, 32'h0000_000E, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters: none; all widths are fixed at 32-bit operands and 32-bit HI/LO.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 srca  input  32  multiplicand / dividend; same operand bus that drives the ALU.
REQ-007 srcb  input  32  multiplier / divisor; same operand bus that drives the ALU.
REQ-008 mthi, mtlo  input  1 each  direct write of wd into HI / LO.
REQ-009 wd  input  32  data for mthi/mtlo.
REQ-010 busy  output  1  an operation is in progress.
REQ-011 done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-012 hi, lo  output  32 each  architectural HI and LO registers.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 Transitions:
- IDLE/DONE -> RUN on start=1; op, srca and srcb are captured at that edge.
- RUN -> DONE when the 5-bit iteration counter reaches 31.
- DONE -> IDLE on start=0.
REQ-015 Outputs by state:
- busy=1 only in RUN.
- done=1 only in DONE.
REQ-016 Latency: with start captured at edge E0, iterations occur at edges E1..E32; hi/lo update and DONE is entered at E32; done is visible for exactly one cycle unless a new start is captured at E33.
REQ-017 start while busy=1 SHALL be ignored; captured operands SHALL NOT change during RUN.
REQ-018 Multiply:
- Radix-2 shift-add, one bit per cycle.
- Result is the full 64-bit product: {hi,lo}.
- MULT treats operands as two's complement; MULTU treats them as unsigned.
REQ-019 Divide:
- Restoring division on magnitudes, one quotient bit per cycle.
- lo = quotient, hi = remainder.
- Signed: quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 with no exception.
REQ-021 Divide by zero SHALL complete with normal latency and give lo=0xFFFFFFFF, hi=srca as captured, for both DIV and DIVU.
REQ-022 HI/LO SHALL hold their previous values during RUN; partial results live only in internal registers.
REQ-023 mthi/mtlo SHALL write wd at the next edge in any state.
REQ-024 If mthi/mtlo coincides with the completion edge E32, the operation result SHALL win.
REQ-025 mthi and mtlo in the same cycle SHALL both write wd.
REQ-026 Back-to-back: start=1 in DONE SHALL launch the next operation at that edge; done then drops in the following cycle.

Reset
REQ-027 reset=1 at a clock edge SHALL force, regardless of state (including mid-RUN):
- state IDLE, counter 0, busy=0, done=0, hi=0, lo=0.
- Any in-flight result is discarded.
REQ-028 reset SHALL take priority over start, mthi and mtlo in the same cycle.
REQ-029 Outputs SHALL be undefined-free (not X) from the first edge with reset=1.

Verification
REQ-030 MULT, srca=3, srcb=0xFFFFFFFA -> after 32 iteration edges: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEE; busy high exactly 32 cycles.
REQ-031 MULTU, srca=3, srcb=0xFFFFFFFA -> hi=0x00000002, lo=0xFFFFFFEE.
REQ-032 DIV 7 / 0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1; DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=0x0000000E, hi=2.
REQ-033 DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678.
REQ-034 Start a MULT, then:
- Assert start again at cycle 5 with different operands -> ignored; result matches the first operands.
- Assert mtlo with wd=0xA5A5A5A5 at cycle 10 -> lo=0xA5A5A5A5 until completion, then overwritten by the product.
REQ-035 Assert reset at cycle 16 of a DIV -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows; a fresh start then completes normally.
